imem_loader: RTL and testbench

- Writer side of the instruction-memory interface. The CPU only ever reads instruction memory; this block fills it.
- Accepts a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
- Writes each word to instruction memory at byte addresses 0, 4, 8, ...
- Holds the CPU in reset while loading, and reports done or error at the end of the frame.

---
 rtl/imem_loader_pkg.sv | 25 ++
 rtl/imem_loader_packer.sv | 43 ++++
 rtl/imem_loader.sv | 131 +++++++++++++
 tb/tb_imem_loader.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding,
// frame field widths and default geometry.
package imem_loader_pkg;

  localparam int LEN_W             = 16;
  localparam int CSUM_W            = 8;
  localparam int DEFAULT_ADDR_W    = 8;
  localparam int DEFAULT_MAX_WORDS = 64;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_e;

  // States in which the loader consumes bytes from the stream.
  function automatic logic accepts_bytes(input state_e s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/imem_loader_packer.sv
// Byte-to-word packer: shifts payload bytes MSB-first into a 32-bit word and
// presents it with a one-cycle word_valid strobe after the fourth byte.
module byte_to_word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte,
  output logic        o_last_byte,
  output logic        o_word_valid,
  output logic [31:0] o_word
);

  logic [1:0]  r_byte_cnt;
  logic [31:0] r_acc;
  logic        r_word_valid;

  assign o_last_byte = i_byte_valid && (r_byte_cnt == 2'd3);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_byte_cnt   <= 2'd0;
      r_acc        <= 32'd0;
      r_word_valid <= 1'b0;
    end else if (i_clear) begin
      r_byte_cnt   <= 2'd0;
      r_acc        <= 32'd0;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= o_last_byte;
      if (i_byte_valid) begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
        r_acc      <= {r_acc[23:0], i_byte};
      end
    end
  end

  assign o_word_valid = r_word_valid;
  assign o_word       = r_acc;

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: framed byte stream in, 32-bit word writes out.
// Keeps the CPU in reset until a complete, checksum-verified image is loaded.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int MAX_WORDS = DEFAULT_MAX_WORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset_hold,
  output logic              done,
  output logic              error
);

  localparam logic [LEN_W-1:0] LP_MAX_WORDS = LEN_W'(MAX_WORDS);

  state_e             r_state;
  state_e             w_next_state;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_word_cnt;
  logic [CSUM_W-1:0]  r_csum;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_in_ready;
  logic               r_hold;
  logic               r_done;
  logic               r_error;

  logic               w_accept;
  logic               w_restart;
  logic               w_pack_valid;
  logic               w_last_byte;
  logic               w_word_valid;
  logic [31:0]        w_word;
  logic [LEN_W-1:0]   w_len_rx;

  assign w_accept     = in_valid && r_in_ready;
  assign w_restart    = start && (r_state inside {ST_IDLE, ST_DONE, ST_ERR});
  assign w_pack_valid = w_accept && (r_state == ST_DATA);
  assign w_len_rx     = {r_len[LEN_W-1:8], in_data};

  byte_to_word_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .i_clear      (w_restart),
    .i_byte_valid (w_pack_valid),
    .i_byte       (in_data),
    .o_last_byte  (w_last_byte),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  // NOTE: next state defaults to the current state before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: if (start) w_next_state = ST_LEN_HI;
      ST_LEN_HI: if (w_accept) w_next_state = ST_LEN_LO;
      ST_LEN_LO: begin
        if (w_accept) begin
          if (w_len_rx > LP_MAX_WORDS)  w_next_state = ST_ERR;
          else if (w_len_rx == '0)      w_next_state = ST_CSUM;
          else                          w_next_state = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_last_byte && (r_word_cnt + LEN_W'(1) == r_len)) w_next_state = ST_CSUM;
      end
      ST_CSUM: begin
        if (w_accept) w_next_state = (in_data == r_csum) ? ST_DONE : ST_ERR;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Word counter and address advance on the write-strobe cycle, so the
  // strobe presents the address of the word being written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_len      <= '0;
      r_word_cnt <= '0;
      r_csum     <= '0;
      r_addr     <= '0;
      r_in_ready <= 1'b0;
      r_hold     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_in_ready <= accepts_bytes(w_next_state);
      if (w_restart) begin
        r_hold     <= 1'b1;
        r_done     <= 1'b0;
        r_error    <= 1'b0;
        r_csum     <= '0;
        r_len      <= '0;
        r_word_cnt <= '0;
        r_addr     <= '0;
      end else begin
        if (w_accept && (r_state != ST_CSUM)) r_csum <= r_csum + in_data;
        if (w_accept && (r_state == ST_LEN_HI)) r_len[LEN_W-1:8] <= in_data;
        if (w_accept && (r_state == ST_LEN_LO)) r_len[7:0] <= in_data;
        if (w_word_valid) begin
          r_addr     <= r_addr + ADDR_W'(4);
          r_word_cnt <= r_word_cnt + LEN_W'(1);
        end
        if ((r_state == ST_CSUM) && (w_next_state == ST_DONE)) r_done <= 1'b1;
        if ((w_next_state == ST_ERR) && (r_state != ST_ERR)) r_error <= 1'b1;
        if (r_state == ST_DONE) r_hold <= 1'b0;
      end
    end
  end

  assign in_ready       = r_in_ready;
  assign imem_we        = w_word_valid;
  assign imem_addr      = r_addr;
  assign imem_wdata     = w_word;
  assign cpu_reset_hold = r_hold;
  assign done           = r_done;
  assign error          = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven frames, hand-written
// corner sequences and randomized frames against a frame-level model.
`timescale 1ns/1ps
module tb_imem_loader;

  localparam int ADDR_W    = 8;
  localparam int MAX_WORDS = 64;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset_hold;
  logic              done;
  logic              error;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .imem_we        (imem_we),
    .imem_addr      (imem_addr),
    .imem_wdata     (imem_wdata),
    .cpu_reset_hold (cpu_reset_hold),
    .done           (done),
    .error          (error)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [39:0] cap_q[$];
  logic [39:0] exp_q[$];
  logic [7:0]  frame_q[$];
  int          exp_consumed;
  logic        exp_done;
  logic        exp_err;

  // Every negedge with the strobe high is one write; a stretched strobe shows up twice.
  always @(negedge clk) if (imem_we) cap_q.push_back({imem_addr, imem_wdata});

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte transferred.
  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && waited < 32) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL ready_wait: in_ready 0 after %0d cycles, wanted 1", waited);
      in_valid = 1'b0;
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_load(input int n, input int gap);
    cap_q.delete();
    pulse_start();
    for (int k = 0; k < n; k++) begin
      if (gap > 0) begin
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
      send_byte(frame_q[k]);
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Frame-level reference: length, big-endian words at 4*i, mod-256 checksum.
  task automatic model_frame();
    int n;
    int sum;
    exp_q.delete();
    n = int'(frame_q[0]) * 256 + int'(frame_q[1]);
    if (n > MAX_WORDS) begin
      exp_consumed = 2;
      exp_done     = 1'b0;
      exp_err      = 1'b1;
    end else begin
      sum = int'(frame_q[0]) + int'(frame_q[1]);
      for (int i = 0; i < n; i++) begin
        exp_q.push_back({8'(4 * i), frame_q[2+4*i], frame_q[3+4*i], frame_q[4+4*i], frame_q[5+4*i]});
        for (int j = 0; j < 4; j++) sum += int'(frame_q[2+4*i+j]);
      end
      exp_consumed = 2 + 4 * n + 1;
      exp_done     = (frame_q[2+4*n] == 8'(sum % 256));
      exp_err      = !exp_done;
    end
  endtask

  task automatic compare_result(input string tag);
    check({tag, " nwrites"}, 64'(cap_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
      check($sformatf("%s write%0d", tag, i), 64'(cap_q[i]), 64'(exp_q[i]));
    check({tag, " done"}, 64'(done), 64'(exp_done));
    check({tag, " error"}, 64'(error), 64'(exp_err));
    check({tag, " hold"}, 64'(cpu_reset_hold), 64'(exp_err));
    check({tag, " ready"}, 64'(in_ready), 64'(0));
  endtask

  typedef struct {
    int          n;
    logic [95:0] bytes;
    int          gap;
    logic        exp_done;
    logic        exp_err;
    int          exp_nw;
    logic [31:0] exp_w0;
    logic [31:0] exp_w1;
  } vec_t;

  vec_t vecs[7];

  task automatic push_normal_frame();
    logic [95:0] f;
    f = 96'h000220080005000000002F00;
    frame_q.delete();
    for (int k = 0; k < 11; k++) frame_q.push_back(f[95-8*k -: 8]);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, wanted $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{11, 96'h000220080005000000002F00, 0, 1'b1, 1'b0, 2, 32'h20080005, 32'h00000000};
    vecs[1] = '{11, 96'h000220080005000000002E00, 0, 1'b0, 1'b1, 2, 32'h20080005, 32'h00000000};
    vecs[2] = '{2,  96'h004100000000000000000000, 0, 1'b0, 1'b1, 0, 32'h0, 32'h0};
    vecs[3] = '{3,  96'h000000000000000000000000, 0, 1'b1, 1'b0, 0, 32'h0, 32'h0};
    vecs[4] = '{11, 96'h000220080005000000002F00, 1, 1'b1, 1'b0, 2, 32'h20080005, 32'h00000000};
    vecs[5] = '{7,  96'h0001DEADBEEF390000000000, 0, 1'b1, 1'b0, 1, 32'hDEADBEEF, 32'h0};
    vecs[6] = '{2,  96'h010000000000000000000000, 0, 1'b0, 1'b1, 0, 32'h0, 32'h0};

    // Power-on reset.
    #3 reset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset outputs", 64'({in_ready, imem_we, imem_addr, imem_wdata, cpu_reset_hold, done, error}), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      frame_q.delete();
      for (int k = 0; k < vecs[v].n; k++) frame_q.push_back(vecs[v].bytes[95-8*k -: 8]);
      do_load(vecs[v].n, vecs[v].gap);
      check($sformatf("vec%0d nwrites", v), 64'(cap_q.size()), 64'(vecs[v].exp_nw));
      if (vecs[v].exp_nw > 0 && cap_q.size() > 0)
        check($sformatf("vec%0d write0", v), 64'(cap_q[0]), 64'({8'h00, vecs[v].exp_w0}));
      if (vecs[v].exp_nw > 1 && cap_q.size() > 1)
        check($sformatf("vec%0d write1", v), 64'(cap_q[1]), 64'({8'h04, vecs[v].exp_w1}));
      check($sformatf("vec%0d done", v), 64'(done), 64'(vecs[v].exp_done));
      check($sformatf("vec%0d error", v), 64'(error), 64'(vecs[v].exp_err));
      check($sformatf("vec%0d hold", v), 64'(cpu_reset_hold), 64'(vecs[v].exp_err));
    end

    // DONE entry: done rises with hold still set; hold drops one cycle later.
    push_normal_frame();
    cap_q.delete();
    pulse_start();
    for (int k = 0; k < 11; k++) send_byte(frame_q[k]);
    in_valid = 1'b0;
    check("done entry done", 64'(done), 64'(1));
    check("done entry hold", 64'(cpu_reset_hold), 64'(1));
    @(negedge clk);
    check("done+1 hold", 64'(cpu_reset_hold), 64'(0));
    check("done nwrites", 64'(cap_q.size()), 64'(2));

    // start in DONE restarts and clears done.
    pulse_start();
    check("restart done", 64'(done), 64'(0));
    check("restart hold", 64'(cpu_reset_hold), 64'(1));
    check("restart ready", 64'(in_ready), 64'(1));

    // start mid-DATA is ignored; the frame continues to a clean finish.
    cap_q.delete();
    for (int k = 0; k < 4; k++) send_byte(frame_q[k]);
    in_valid = 1'b0;
    pulse_start();
    for (int k = 4; k < 11; k++) send_byte(frame_q[k]);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    model_frame();
    compare_result("start mid-data");

    // Reset mid-load after five payload bytes.
    cap_q.delete();
    pulse_start();
    for (int k = 0; k < 7; k++) send_byte(frame_q[k]);
    in_valid = 1'b0;
    check("midload hold", 64'(cpu_reset_hold), 64'(1));
    reset = 1'b1;
    #1;
    check("midload reset outputs", 64'({in_ready, imem_we, imem_addr, imem_wdata, cpu_reset_hold, done, error}), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (2) @(negedge clk);
    check("post reset idle ready", 64'(in_ready), 64'(0));
    in_valid = 1'b0;
    do_load(11, 0);
    model_frame();
    compare_result("after reset");

    // Maximum-size image: last write lands at 4*(MAX_WORDS-1).
    begin
      int sum;
      frame_q.delete();
      frame_q.push_back(8'h00);
      frame_q.push_back(8'(MAX_WORDS));
      sum = MAX_WORDS;
      for (int i = 0; i < 4 * MAX_WORDS; i++) begin
        frame_q.push_back(8'($urandom_range(0, 255)));
        sum += int'(frame_q[frame_q.size()-1]);
      end
      frame_q.push_back(8'(sum % 256));
      model_frame();
      do_load(exp_consumed, 0);
      compare_result("max image");
      if (cap_q.size() == MAX_WORDS)
        check("max last addr", 64'(cap_q[MAX_WORDS-1][39:32]), 64'(4 * (MAX_WORDS - 1)));
    end

    // Randomized frames, each restarting from the previous DONE/ERR.
    for (int t = 0; t < 24; t++) begin
      int n;
      int sum;
      logic [7:0] cs;
      n = ($urandom_range(0, 5) == 0) ? int'($urandom_range(60, 70)) : int'($urandom_range(0, 8));
      frame_q.delete();
      frame_q.push_back(8'(n / 256));
      frame_q.push_back(8'(n % 256));
      sum = n;
      if (n <= MAX_WORDS) begin
        for (int i = 0; i < 4 * n; i++) begin
          frame_q.push_back(8'($urandom_range(0, 255)));
          sum += int'(frame_q[frame_q.size()-1]);
        end
      end
      cs = 8'(sum % 256);
      if ($urandom_range(0, 3) == 0) cs = cs ^ 8'($urandom_range(1, 255));
      frame_q.push_back(cs);
      model_frame();
      do_load(exp_consumed, int'($urandom_range(0, 1)));
      compare_result($sformatf("rand%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
